// File: rtl/fetch_pkg.sv
// ============================================================================
// Module : fetch_pkg
// Desc   : Shared types, widths and helpers for the fetch queue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam int CPU_ADDR_BITS   = 32;
    localparam int CPU_INST_BITS   = 32;

    localparam int FQ_DEPTH        = 16;
    localparam int FQ_FETCH_WIDTH  = 2;
    localparam int FQ_DECODE_WIDTH = 2;
    localparam int FQ_PTR_W        = $clog2(FQ_DEPTH);
    localparam int FQ_CNT_W        = $clog2(FQ_DEPTH + 1);

    typedef struct packed {
        logic [CPU_INST_BITS-1:0] inst;
        logic [CPU_ADDR_BITS-1:0] pc;
    } fq_entry_t;

    function automatic logic [7:0] popcount(input logic [63:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fq_compact.sv
// ============================================================================
// Module : fq_compact
// Desc   : Packs the set lanes of a fetch packet in ascending lane order.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fq_compact
    import fetch_pkg::*;
#(
    parameter int FETCH_WIDTH = FQ_FETCH_WIDTH,
    parameter int NIN_W       = $clog2(FETCH_WIDTH + 1)
) (
    input  logic [CPU_ADDR_BITS-1:0]             fetch_pc,
    input  logic [FETCH_WIDTH-1:0]               fetch_mask,
    input  logic [FETCH_WIDTH*CPU_INST_BITS-1:0] fetch_insts,
    output fq_entry_t                            ents [FETCH_WIDTH],
    output logic [NIN_W-1:0]                     n_in
);

    localparam int IDX_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

    logic [IDX_W-1:0] slot;

    // PC follows the original lane position, not the packed position.
    always_comb begin
        slot = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            ents[i] = '0;
        end
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (fetch_mask[i]) begin
                ents[slot].inst = fetch_insts[i*CPU_INST_BITS +: CPU_INST_BITS];
                ents[slot].pc   = fetch_pc + CPU_ADDR_BITS'(4 * i);
                slot            = slot + IDX_W'(1);
            end
        end
    end

    assign n_in = NIN_W'(popcount(64'(fetch_mask)));

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module : fetch_queue
// Desc   : Instruction-granular circular queue between fetch and decode.
//          FQ_BYPASS_EN : empty-queue fetch lanes forwarded to decode same cycle.
//          FQ_SVA_EN    : enables the dec_take over-request assertion.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH        = FQ_DEPTH,
    parameter int FETCH_WIDTH  = FQ_FETCH_WIDTH,
    parameter int DECODE_WIDTH = FQ_DECODE_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic                                  fetch_val,
    input  logic [CPU_ADDR_BITS-1:0]              fetch_pc,
    input  logic [FETCH_WIDTH-1:0]                fetch_mask,
    input  logic [FETCH_WIDTH*CPU_INST_BITS-1:0]  fetch_insts,
    output logic                                  fq_rdy,
    output logic [DECODE_WIDTH-1:0]               dec_val,
    output logic [DECODE_WIDTH*CPU_INST_BITS-1:0] dec_insts,
    output logic [DECODE_WIDTH*CPU_ADDR_BITS-1:0] dec_pcs,
    input  logic [$clog2(DECODE_WIDTH+1)-1:0]     dec_take,
    output logic [$clog2(DEPTH+1)-1:0]            fq_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int NIN_W = $clog2(FETCH_WIDTH + 1);

    fq_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    fq_entry_t        comp [FETCH_WIDTH];
    logic [NIN_W-1:0] n_in;
    logic             enq;
    logic             bypass;
    logic [CNT_W-1:0] n_in_c, avail, take_c, n_out, skip;

    fq_compact #(
        .FETCH_WIDTH (FETCH_WIDTH),
        .NIN_W       (NIN_W)
    ) u_compact (
        .fetch_pc    (fetch_pc),
        .fetch_mask  (fetch_mask),
        .fetch_insts (fetch_insts),
        .ents        (comp),
        .n_in        (n_in)
    );

    assign fq_rdy   = (CNT_W'(DEPTH) - count_q) >= CNT_W'(FETCH_WIDTH);
    assign fq_count = count_q;
    assign enq      = fetch_val & fq_rdy;
    assign n_in_c   = enq ? CNT_W'(n_in) : '0;

`ifdef FQ_BYPASS_EN
    assign bypass = enq && (count_q == '0);
`else
    assign bypass = 1'b0;
`endif

    // Over-requests clamp to what is actually presented this cycle.
    assign avail  = bypass ? n_in_c : count_q;
    assign take_c = CNT_W'(dec_take);
    assign n_out  = (take_c > avail) ? avail : take_c;
    // Bypassed lanes consumed immediately never occupy a slot.
    assign skip   = bypass ? n_out : '0;

    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(n_out);
        wr_ptr_d = wr_ptr_q + PTR_W'(n_in_c);
        count_d  = count_q + n_in_c - n_out;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (!flush && (CNT_W'(k) < n_in_c) && (CNT_W'(k) >= skip)) begin
                mem_q[wr_ptr_q + PTR_W'(k)] <= comp[k];
            end
        end
    end

    for (genvar j = 0; j < DECODE_WIDTH; j++) begin : g_dec
        fq_entry_t ent, byp_ent;
        logic      val, byp_val;

        if (j < FETCH_WIDTH) begin : g_lane
            assign byp_ent = comp[j];
            assign byp_val = CNT_W'(n_in) > CNT_W'(j);
        end else begin : g_nolane
            assign byp_ent = '0;
            assign byp_val = 1'b0;
        end

        assign ent = bypass ? byp_ent : mem_q[rd_ptr_q + PTR_W'(j)];
        assign val = bypass ? byp_val : (count_q > CNT_W'(j));

        assign dec_val[j]                                   = val;
        assign dec_insts[j*CPU_INST_BITS +: CPU_INST_BITS] = ent.inst;
        assign dec_pcs[j*CPU_ADDR_BITS +: CPU_ADDR_BITS]   = ent.pc;
    end

`ifdef FQ_SVA_EN
    a_no_overtake: assert property (@(posedge clk) disable iff (!rst_n || flush)
                                    take_c <= avail);
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// Module : tb_fetch_queue
// Desc   : Directed and scoreboard checks for fetch_queue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_queue;
    import fetch_pkg::*;

    localparam logic [31:0] K = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        fetch_val;
    logic [31:0] fetch_pc;
    logic [1:0]  fetch_mask;
    logic [63:0] fetch_insts;
    logic        fq_rdy;
    logic [1:0]  dec_val;
    logic [63:0] dec_insts;
    logic [63:0] dec_pcs;
    logic [1:0]  dec_take;
    logic [4:0]  fq_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .fetch_val   (fetch_val),
        .fetch_pc    (fetch_pc),
        .fetch_mask  (fetch_mask),
        .fetch_insts (fetch_insts),
        .fq_rdy      (fq_rdy),
        .dec_val     (dec_val),
        .dec_insts   (dec_insts),
        .dec_pcs     (dec_pcs),
        .dec_take    (dec_take),
        .fq_count    (fq_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_val  = 1'b0;
        fetch_mask = 2'b00;
        dec_take   = 2'd0;
        flush      = 1'b0;
    endtask

    task automatic pkt(input logic [31:0] pc, input logic [1:0] m);
        fetch_val   = 1'b1;
        fetch_pc    = pc;
        fetch_mask  = m;
        fetch_insts = {(pc + 32'd4) ^ K, pc ^ K};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] sb [$];
        logic [31:0] pc_ctr;
        logic [31:0] exp_pc;
        logic [1:0]  m;
        logic        fv, rdy_m, enq_m;
        int          tk, avail, nout;

        rst_n       = 1'b0;
        fetch_pc    = '0;
        fetch_insts = '0;
        idle();

        // Reset
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        chk("rst_dec_val", dec_val, 2'b00);
        chk("rst_count", fq_count, 5'd0);
        chk("rst_rdy", fq_rdy, 1'b1);

        // Compaction: only lane 1 set
        fetch_val   = 1'b1;
        fetch_pc    = 32'h100;
        fetch_mask  = 2'b10;
        fetch_insts = {32'h0000_AAAA, 32'h0000_1111};
        tick();
        idle();
        chk("cmp_dec_val", dec_val, 2'b01);
        chk("cmp_pc0", dec_pcs[31:0], 32'h104);
        chk("cmp_inst0", dec_insts[31:0], 32'h0000_AAAA);
        chk("cmp_count", fq_count, 5'd1);
        dec_take = 2'd1;
        tick();
        idle();
        chk("cmp_drain", fq_count, 5'd0);

        // Fill to full
        for (int p = 0; p < 8; p++) begin
            pkt(32'h1000 + 32'(8 * p), 2'b11);
            tick();
        end
        idle();
        chk("full_count", fq_count, 5'd16);
        chk("full_rdy", fq_rdy, 1'b0);
        chk("full_pc0", dec_pcs[31:0], 32'h1000);
        chk("full_pc1", dec_pcs[63:32], 32'h1004);
        chk("full_inst1", dec_insts[63:32], 32'h1004 ^ K);
        pkt(32'h2000, 2'b11);
        dec_take = 2'd1;
        tick();
        idle();
        chk("refuse_count", fq_count, 5'd15);
        chk("refuse_rdy", fq_rdy, 1'b0);
        chk("refuse_pc0", dec_pcs[31:0], 32'h1004);
        dec_take = 2'd1;
        tick();
        idle();
        chk("c14_count", fq_count, 5'd14);
        chk("c14_rdy", fq_rdy, 1'b1);
        chk("c14_pc0", dec_pcs[31:0], 32'h1008);
        repeat (4) begin
            dec_take = 2'd2;
            tick();
        end
        dec_take = 2'd1;
        tick();
        idle();
        chk("c5_count", fq_count, 5'd5);
        chk("c5_pc0", dec_pcs[31:0], 32'h102C);
        chk("c5_dec_val", dec_val, 2'b11);

        // Flush beats same-cycle enqueue and dequeue
        pkt(32'h3000, 2'b11);
        dec_take = 2'd2;
        flush    = 1'b1;
        tick();
        idle();
        chk("flush_count", fq_count, 5'd0);
        chk("flush_dec_val", dec_val, 2'b00);
        chk("flush_rdy", fq_rdy, 1'b1);
        pkt(32'h3100, 2'b01);
        tick();
        idle();
        chk("postflush_pc0", dec_pcs[31:0], 32'h3100);
        chk("postflush_count", fq_count, 5'd1);

        // Over-take clamps
        dec_take = 2'd2;
        tick();
        idle();
        chk("ovt_count", fq_count, 5'd0);
        chk("ovt_dec_val", dec_val, 2'b00);
        pkt(32'h3200, 2'b11);
        tick();
        idle();
        chk("ovt_next_count", fq_count, 5'd2);
        chk("ovt_next_pc0", dec_pcs[31:0], 32'h3200);
        chk("ovt_next_pc1", dec_pcs[63:32], 32'h3204);
        dec_take = 2'd2;
        tick();
        idle();
        chk("ovt_drain", fq_count, 5'd0);

`ifdef FQ_BYPASS_EN
        pkt(32'h4000, 2'b11);
        dec_take = 2'd2;
        #1;
        chk("byp_dec_val", dec_val, 2'b11);
        chk("byp_pc0", dec_pcs[31:0], 32'h4000);
        chk("byp_pc1", dec_pcs[63:32], 32'h4004);
        tick();
        idle();
        chk("byp_count", fq_count, 5'd0);
`endif

        // Random traffic against a program-order scoreboard
        pc_ctr = 32'h8000;
        for (int c = 0; c < 220; c++) begin
            m  = 2'($urandom_range(0, 3));
            fv = ($urandom_range(0, 3) != 0);
            tk = int'($urandom_range(0, 2));
            idle();
            if (fv) pkt(pc_ctr, m);
            dec_take = 2'(tk);
            #1;
            rdy_m = (16 - sb.size()) >= 2;
            enq_m = fv && rdy_m;
            chk("rnd_count", fq_count, 64'(sb.size()));
            chk("rnd_rdy", fq_rdy, rdy_m);
            avail = sb.size();
`ifdef FQ_BYPASS_EN
            if (enq_m && avail == 0) avail = int'(m[0]) + int'(m[1]);
`endif
            if (enq_m) begin
                for (int i = 0; i < 2; i++) begin
                    if (m[i]) sb.push_back(pc_ctr + 32'(4 * i));
                end
                pc_ctr = pc_ctr + 32'd8;
            end
            nout = (tk > avail) ? avail : tk;
            for (int j = 0; j < nout; j++) begin
                exp_pc = sb.pop_front();
                chk("rnd_pc", dec_pcs[j*32 +: 32], exp_pc);
                chk("rnd_inst", dec_insts[j*32 +: 32], exp_pc ^ K);
            end
            tick();
        end
        idle();
        chk("rnd_end_count", fq_count, 64'(sb.size()));
        repeat (10) begin
            dec_take = 2'd2;
            tick();
        end
        idle();
        sb.delete();
        chk("rnd_drained", fq_count, 5'd0);

        // Asynchronous reset mid-cycle
        pkt(32'h5000, 2'b11);
        tick();
        idle();
        chk("arst_pre_count", fq_count, 5'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_count", fq_count, 5'd0);
        chk("arst_dec_val", dec_val, 2'b00);
        chk("arst_rdy", fq_rdy, 1'b1);
        tick();
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
